rr_grant_scheduler: RTL and testbench
=====================================

# rr_grant_scheduler

Round-robin scheduler that shares one priority-encoded resource among `N_REQ` requesters. Each requester holds a request line. The scheduler grants exactly one requester at a time and holds that grant until the owner signals `done` or withdraws its request. Fairness comes from a rotating priority pointer placed in front of a lowest-index-first priority encode, so this block sits between the requester bank and the shared datapath.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `MAX_HOLD`, default 16: maximum grant length in cycles; used only when `RR_SCHED_TIMEOUT_EN` is defined; must be ≥ 1.
- `IDX_W`, default `$clog2(N_REQ)`: width of the index outputs; derived, never overridden.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `req`  in  `N_REQ`  request lines, level-sensitive, one per requester.
- `done`  in  1  the current owner finished; sampled only in BUSY.
- `grant`  out  `N_REQ`  one-hot grant vector, or all zero.
- `grant_idx`  out  `IDX_W`  encoded index of the granted requester.
- `grant_valid`  out  1  a grant is active; equals `|grant`.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- State machine with two states, IDLE and BUSY.
- **IDLE**
  - If `req` is zero, stay in IDLE.
  - Otherwise form `masked = req & ~((1 << ptr) - 1)`.
  - Winner is the lowest set bit of `masked` if `masked` is nonzero, otherwise the lowest set bit of `req`.
  - At the next edge, register `grant = 1 << winner` and `grant_idx = winner`, then enter BUSY.
- **BUSY**, release conditions:
  - `done == 1`, or
  - `req[grant_idx] == 0` (abandon), or
  - timeout (only when the macro is defined).
- On release, at the next edge:
  - `grant` becomes 0 and `grant_idx` keeps its last value.
  - `ptr` becomes `(grant_idx + 1) mod N_REQ`.
  - State returns to IDLE.
- Multiple release conditions in the same cycle count as a single release: one pointer advance, and at most one `timeout` pulse.
- `done` asserted in IDLE is ignored.
- Changes to `req` on non-owner lines during BUSY have no effect.
- `grant` is never multi-hot.
- `ptr` is internal, `IDX_W` wide, and wraps from `N_REQ-1` to 0. For non-power-of-two `N_REQ`, `ptr` never holds a value ≥ `N_REQ`.
- `grant_idx` assignment truncates the integer index to `IDX_W` bits; no out-of-range value ever occurs.

## Timing
- **Reset values:** `grant = 0`, `grant_idx = 0`, `grant_valid = 0`, `timeout = 0`, `ptr = 0`, state IDLE, hold counter 0.
- **Reset during BUSY:** at that edge, `grant` is dropped with no pointer advance and no `timeout` pulse.
- **Grant latency:** `req` seen in IDLE at edge *n* produces the grant on outputs after edge *n*, i.e. one cycle.
- **Release latency:** a release condition in cycle *n* drops `grant` after edge *n*.
- **Bubble:** the earliest next grant appears one cycle after release, because of one mandatory IDLE cycle. Back-to-back ownership spacing is therefore at least 1 idle cycle.
- **Minimum grant:** one cycle, when `done` is high in the first BUSY cycle.
- `timeout` is registered and high for exactly the one cycle in which `grant` first reads 0 after a forced release.

## Configuration
- Macro: `RR_SCHED_TIMEOUT_EN`.
- **Defined:**
  - A hold counter clears on BUSY entry and increments each BUSY cycle.
  - When the counter equals `MAX_HOLD-1` and no other release condition is present, the grant is released as described above and `timeout` pulses.
  - A grant therefore lasts at most `MAX_HOLD` cycles.
- **Undefined:**
  - The counter is not built.
  - `timeout` is tied to 0.
  - Grants last until `done` or abandon.

## Test plan
All scenarios use `N_REQ = 4`.
- **Reset:** hold `rst_n = 0` for 2 cycles with `req = 4'b1111` → all outputs are 0. After `rst_n = 1`, `grant = 4'b0001` and `grant_idx = 0` appear one cycle later.
- **Rotation:** `req = 4'b1111` held, one-cycle `done` in each grant's first BUSY cycle → `grant_idx` sequence 0, 1, 2, 3, 0, with `grant_valid` low for exactly 1 cycle between grants.
- **Pointer masking:**
  - After a grant to index 1 is released, `ptr = 2`. Then `req = 4'b0011` → grant idx 0.
  - With `ptr = 2`, `req = 4'b1010` → grant idx 3, then `ptr = 0`.
- **Abandon and simultaneity:**
  - Owner idx 2 drops `req[2]` with no `done` → `grant` drops next cycle, `ptr = 3`, `timeout = 0`.
  - `done` and the owner's `req` drop in the same cycle → single release, `ptr` advances once.
  - `done` asserted in IDLE → no effect.
- **Timeout** (macro defined, `MAX_HOLD = 4`): `req = 4'b0101` held, `done = 0` → idx 0 granted for exactly 4 cycles, `timeout` pulses once, `ptr = 1`, next grant is idx 2. With the macro undefined, idx 0 stays granted indefinitely and `timeout` stays 0.
- **Mid-grant reset:** `rst_n = 0` while idx 3 is granted → all outputs 0 next cycle, `ptr = 0`. After release of reset with `req = 4'b1000`, the next grant is idx 3.

Source files
------------

// File: rtl/rr_grant_scheduler.sv
// ----------------------------------------------------------------------------
// rr_grant_scheduler
//
// Round-robin arbiter that hands one shared resource to one of N_REQ
// requesters at a time. It uses a rotating priority pointer in front of a
// lowest-index-first priority encode. A grant is held until the owner raises
// `done` or drops its request line. Each release is followed by one mandatory
// IDLE cycle before the next grant.
//
// Optional feature (compile-time macro RR_SCHED_TIMEOUT_EN):
//   When defined, a hold counter forcibly revokes any grant after MAX_HOLD
//   cycles and pulses `timeout` for one cycle. When undefined, the counter is
//   not built and `timeout` is tied to 0.
//
// Parameters:
//   N_REQ     number of requesters (>= 2)
//   MAX_HOLD  maximum grant length in cycles when timeout is enabled (>= 1)
//   IDX_W     width of index outputs, derived from N_REQ
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   req          level-sensitive request lines, one per requester
//   done         current owner finished (only sampled while BUSY)
//   grant        one-hot grant vector, or all zero
//   grant_idx    encoded index of the granted requester (holds last value)
//   grant_valid  a grant is active (|grant)
//   timeout      one-cycle pulse when a grant was forcibly revoked
// ----------------------------------------------------------------------------
module rr_grant_scheduler #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDX_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    generate
        if (N_REQ < 2 || MAX_HOLD < 1) begin : g_param_check
            $error("rr_grant_scheduler: N_REQ must be >= 2 and MAX_HOLD >= 1");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] low_idx;
    logic [IDX_W-1:0] msk_idx;
    logic             msk_hit;
    logic             user_rel;
    logic             force_rel;
    logic             hold_expired;

`ifdef RR_SCHED_TIMEOUT_EN
    // MAX_HOLD-1 is the largest value the counter reaches, so this width suffices.
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    assign hold_expired = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
    assign timeout      = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    // Rotating-priority encode. Bits at or above ptr form the masked set.
    // The descending scan leaves the lowest set index in each candidate.
    // If nothing is set at or above ptr, the winner wraps to the lowest request.
    always_comb begin
        low_idx = '0;
        msk_idx = '0;
        msk_hit = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                low_idx = IDX_W'(i);
            end
            if (req[i] && (i >= int'(ptr_q))) begin
                msk_idx = IDX_W'(i);
                msk_hit = 1'b1;
            end
        end
        win_idx = msk_hit ? msk_idx : low_idx;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
`ifdef RR_SCHED_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
`endif
        user_rel  = done || !req[grant_idx_q];
        // Timeout counts only when nothing else releases, so coincident
        // conditions yield one release and no spurious pulse.
        force_rel = hold_expired && !user_rel;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    grant_idx_d      = win_idx;
                    state_d          = ST_BUSY;
`ifdef RR_SCHED_TIMEOUT_EN
                    hold_cnt_d       = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (user_rel || force_rel) begin
                    grant_d = '0;
                    ptr_d   = (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0
                                                                 : grant_idx_q + 1'b1;
                    state_d = ST_IDLE;
`ifdef RR_SCHED_TIMEOUT_EN
                    timeout_d = force_rel;
`endif
                end else begin
`ifdef RR_SCHED_TIMEOUT_EN
                    hold_cnt_d = hold_cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
`ifdef RR_SCHED_TIMEOUT_EN
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
`ifdef RR_SCHED_TIMEOUT_EN
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = |grant_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// ----------------------------------------------------------------------------
// tb_rr_grant_scheduler
//
// Bench for rr_grant_scheduler with N_REQ = 4 and MAX_HOLD = 4. Each step
// task call drives one cycle of inputs. It runs a behavioural model of the
// scheduler, pushes the predicted post-edge outputs onto a queue, and pops
// and compares them after the edge. The scenario tasks add directed checks
// against fixed expected values.
// ----------------------------------------------------------------------------
module tb_rr_grant_scheduler;

    localparam int N_REQ    = 4;
    localparam int MAX_HOLD = 4;
`ifdef RR_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic       done  = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    always #5 clk = ~clk;

    rr_grant_scheduler #(
        .N_REQ    (N_REQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] idx;
        logic       v;
        logic       t;
        logic [1:0] p;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural reference state
    bit         m_busy  = 1'b0;
    logic [1:0] m_ptr   = 2'd0;
    logic [1:0] m_idx   = 2'd0;
    logic [3:0] m_grant = 4'b0000;
    bit         m_to    = 1'b0;
    int         m_cnt   = 0;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_step(input logic r_n, input logic [3:0] r, input logic d);
        logic [3:0] masked;
        bit rel, frc;
        if (!r_n) begin
            m_busy = 1'b0; m_ptr = 2'd0; m_idx = 2'd0;
            m_grant = 4'b0000; m_to = 1'b0; m_cnt = 0;
        end else if (!m_busy) begin
            m_to = 1'b0;
            if (r != 4'b0000) begin
                masked  = r & ~((4'b0001 << m_ptr) - 4'b0001);
                m_idx   = 2'(lowest((masked != 4'b0000) ? masked : r));
                m_grant = 4'b0001 << m_idx;
                m_busy  = 1'b1;
                m_cnt   = 0;
            end
        end else begin
            rel = d || !r[m_idx];
            frc = TO_EN && !rel && (m_cnt == MAX_HOLD - 1);
            if (rel || frc) begin
                m_grant = 4'b0000;
                m_ptr   = 2'((int'(m_idx) + 1) % N_REQ);
                m_busy  = 1'b0;
                m_to    = frc;
            end else begin
                m_to  = 1'b0;
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    // One clock cycle: drive inputs, predict, clock, compare.
    task automatic step(input logic r_n, input logic [3:0] r, input logic d);
        obs_t e, a;
        rst_n = r_n;
        req   = r;
        done  = d;
        model_step(r_n, r, d);
        exp_q.push_back({m_grant, m_idx, |m_grant, m_to, m_ptr});
        @(posedge clk);
        #1;
        a = {grant, grant_idx, grant_valid, timeout, dut.ptr_q};
        e = exp_q.pop_front();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t: got g=%b idx=%0d v=%b to=%b ptr=%0d, want g=%b idx=%0d v=%b to=%b ptr=%0d",
                     $time, a.g, a.idx, a.v, a.t, a.p, e.g, e.idx, e.v, e.t, e.p);
        end
    endtask

    task automatic test_reset();
        step(1'b0, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        checks++;
        if ({grant, grant_idx, grant_valid, timeout} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got g=%b idx=%0d v=%b to=%b, want all 0",
                     grant, grant_idx, grant_valid, timeout);
        end
        step(1'b1, 4'b1111, 1'b0);
        checks++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_grant: got g=%b idx=%0d, want g=0001 idx=0", grant, grant_idx);
        end
    endtask

    task automatic test_rotation();
        int seq[$];
        int last;
        step(1'b0, 4'b1111, 1'b0);
        last = -1;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 4'b1111, grant_valid);
            if (grant_valid) begin
                seq.push_back(int'(grant_idx));
                if (last >= 0) begin
                    checks++;
                    if (i - last - 1 != 1) begin
                        errors++;
                        $display("FAIL rotation_gap: got %0d idle cycles, want 1", i - last - 1);
                    end
                end
                last = i;
            end
        end
        checks++;
        if (seq.size() != 5) begin
            errors++;
            $display("FAIL rotation_count: got %0d grants, want 5", seq.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (seq[k] != (k % 4)) begin
                    errors++;
                    $display("FAIL rotation_idx[%0d]: got %0d, want %0d", k, seq[k], k % 4);
                end
            end
        end
    endtask

    task automatic test_masking();
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0010, 1'b1);
        checks++;
        if (dut.ptr_q !== 2'd2) begin
            errors++;
            $display("FAIL mask_ptr_after_idx1: got %0d, want 2", dut.ptr_q);
        end
        step(1'b1, 4'b0011, 1'b0);
        checks++;
        if (grant_idx !== 2'd0 || grant !== 4'b0001) begin
            errors++;
            $display("FAIL mask_wrap_0011: got idx=%0d g=%b, want idx=0 g=0001", grant_idx, grant);
        end
        step(1'b1, 4'b0011, 1'b1);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0010, 1'b1);
        step(1'b1, 4'b1010, 1'b0);
        checks++;
        if (grant_idx !== 2'd3 || grant !== 4'b1000) begin
            errors++;
            $display("FAIL mask_1010: got idx=%0d g=%b, want idx=3 g=1000", grant_idx, grant);
        end
        step(1'b1, 4'b1010, 1'b1);
        checks++;
        if (dut.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL mask_ptr_wrap: got %0d, want 0", dut.ptr_q);
        end
    endtask

    task automatic test_abandon();
        step(1'b1, 4'b0100, 1'b0);
        checks++;
        if (grant_idx !== 2'd2) begin
            errors++;
            $display("FAIL abandon_setup: got idx=%0d, want 2", grant_idx);
        end
        step(1'b1, 4'b0000, 1'b0);
        checks++;
        if (grant !== 4'b0000 || dut.ptr_q !== 2'd3 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL abandon_release: got g=%b ptr=%0d to=%b, want g=0000 ptr=3 to=0",
                     grant, dut.ptr_q, timeout);
        end
        step(1'b1, 4'b1000, 1'b0);
        step(1'b1, 4'b0000, 1'b1);
        checks++;
        if (grant !== 4'b0000 || dut.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL simul_release: got g=%b ptr=%0d, want g=0000 ptr=0", grant, dut.ptr_q);
        end
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        checks++;
        if (grant !== 4'b0000 || dut.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL done_in_idle: got g=%b ptr=%0d, want g=0000 ptr=0", grant, dut.ptr_q);
        end
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        checks++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL nonowner_change: got g=%b idx=%0d, want g=0001 idx=0", grant, grant_idx);
        end
        step(1'b1, 4'b0001, 1'b1);
    endtask

    task automatic test_timeout();
        int n_own0, n_to, next_idx;
        bit seen_to;
        step(1'b0, 4'b0000, 1'b0);
        n_own0 = 0; n_to = 0; next_idx = -1; seen_to = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b0101, 1'b0);
            if (grant === 4'b0001) n_own0++;
            if (timeout === 1'b1) begin
                n_to++;
                seen_to = 1'b1;
                checks++;
                if (grant !== 4'b0000) begin
                    errors++;
                    $display("FAIL timeout_with_grant: got g=%b, want 0000", grant);
                end
            end
            if (seen_to && grant_valid && next_idx < 0) next_idx = int'(grant_idx);
        end
        checks++;
        if (TO_EN) begin
            if (n_own0 != 4 || n_to != 1 || next_idx != 2) begin
                errors++;
                $display("FAIL timeout_enabled: got hold=%0d pulses=%0d next=%0d, want hold=4 pulses=1 next=2",
                         n_own0, n_to, next_idx);
            end
        end else begin
            if (n_own0 != 8 || n_to != 0) begin
                errors++;
                $display("FAIL timeout_disabled: got hold=%0d pulses=%0d, want hold=8 pulses=0",
                         n_own0, n_to);
            end
        end
    endtask

    task automatic test_midreset();
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0010, 1'b1);
        step(1'b1, 4'b1000, 1'b0);
        checks++;
        if (grant_idx !== 2'd3) begin
            errors++;
            $display("FAIL midreset_setup: got idx=%0d, want 3", grant_idx);
        end
        step(1'b0, 4'b1000, 1'b0);
        checks++;
        if ({grant, grant_idx, grant_valid, timeout} !== 8'h00 || dut.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL midreset_clear: got g=%b idx=%0d v=%b to=%b ptr=%0d, want all 0",
                     grant, grant_idx, grant_valid, timeout, dut.ptr_q);
        end
        step(1'b1, 4'b1000, 1'b0);
        checks++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
            errors++;
            $display("FAIL midreset_regrant: got g=%b idx=%0d, want g=1000 idx=3", grant, grant_idx);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_rotation();
        test_masking();
        test_abandon();
        test_timeout();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
